// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the systolic array: loads a DIM x DIM row-major matrix from the
// operand RAM into a local buffer, then streams it to the row inputs with diagonal skew.
module systolic_operand_feeder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DIM    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_di,
    input  logic [DATA_W-1:0]     ram_do,
    output logic [DIM*DATA_W-1:0] out_data,
    output logic [DIM-1:0]        out_lane_vld,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int NELEM  = DIM * DIM;
    localparam int CNT_W  = $clog2(NELEM);
    localparam int NSTEP  = 2 * DIM - 1;
    localparam int STEP_W = $clog2(NSTEP + 1);
    localparam logic [CNT_W-1:0]  LAST_RD   = CNT_W'(NELEM - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   base_q;
    logic [CNT_W-1:0]    rd_cnt;
    logic [CNT_W-1:0]    cap_idx;
    logic                cap_vld;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   nstep;
    logic [DATA_W-1:0]   opbuf [NELEM];
    logic [DIM*DATA_W-1:0] nxt_data;
    logic [DIM-1:0]      nxt_vld;
    logic                last_step;
    logic                load_out;

    assign ram_en    = (state == S_LOAD);
    assign ram_we    = 1'b0;
    assign ram_di    = '0;
    assign ram_addr  = base_q + ADDR_W'(rd_cnt);
    assign busy      = (state != S_IDLE);
    assign last_step = (state == S_STREAM) && (step == LAST_STEP);
    assign load_out  = (state == S_DRAIN) || ((state == S_STREAM) && (step != LAST_STEP));
    // Output registers run one step ahead of the counter they are loaded from.
    assign nstep     = (state == S_STREAM) ? step + STEP_W'(1) : '0;

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        int              col;
        logic [CNT_W-1:0] idx;
        logic            v;
        logic [DATA_W-1:0] d;
        always_comb begin
            col = int'(nstep) - i;
            v   = (col >= 0) && (col < DIM);
            idx = CNT_W'(i * DIM + col);
            d   = '0;
            if (v) d = opbuf[idx];
        end
        assign nxt_data[i*DATA_W +: DATA_W] = d;
        assign nxt_vld[i] = v;
    end

    // Buffer holds no reset; it is always fully rewritten before being streamed.
    always_ff @(posedge clk) begin
        if (cap_vld) opbuf[cap_idx] <= ram_do;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            base_q       <= '0;
            rd_cnt       <= '0;
            step         <= '0;
            cap_vld      <= 1'b0;
            cap_idx      <= '0;
            out_data     <= '0;
            out_lane_vld <= '0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
        end else begin
            cap_vld <= (state == S_LOAD);
            cap_idx <= rd_cnt;
            done    <= last_step;
            if (load_out) begin
                out_data     <= nxt_data;
                out_lane_vld <= nxt_vld;
                out_valid    <= 1'b1;
            end else begin
                out_data     <= '0;
                out_lane_vld <= '0;
                out_valid    <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q <= base_addr;
                        rd_cnt <= '0;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (rd_cnt == LAST_RD) state <= S_DRAIN;
                    else rd_cnt <= rd_cnt + CNT_W'(1);
                end
                S_DRAIN: begin
                    step  <= '0;
                    state <= S_STREAM;
                end
                S_STREAM: begin
                    if (step == LAST_STEP) state <= S_IDLE;
                    else step <= step + STEP_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
- Read side of the operand RAM for the systolic array.
- On a start pulse, reads a DIM x DIM operand matrix stored row-major in the single-port operand RAM, starting at a programmable base address, into a local buffer.
- Then streams the matrix into the array's row inputs with diagonal skew: row i is delayed i cycles.
- Sits between the operand RAM (1-cycle registered read latency) and the array's edge PEs.

Parameters:
- DATA_W, 16, operand width; must equal the RAM output width.
- ADDR_W, 4, RAM address width.
- DIM, 2, array dimension. Legal range 2..8; DIM*DIM must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request one load+stream pass; sampled only when busy=0.
- base_addr  input  ADDR_W  address of A[0][0]; latched when start is accepted.
- ram_en  output  1  RAM enable.
- ram_we  output  1  RAM write enable; constant 0.
- ram_addr  output  ADDR_W  RAM read address.
- ram_di  output  DATA_W  RAM write data; constant 0.
- ram_do  input  DATA_W  RAM read data; valid the cycle after ram_en=1.
- out_data  output  DIM*DATA_W  packed lane data; lane i occupies bits [i*DATA_W +: DATA_W].
- out_lane_vld  output  DIM  per-lane valid.
- out_valid  output  1  stream beat active.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE; all counters clear.
  - ram_en, out_valid, done clear; out_data and out_lane_vld clear.
  - Buffer contents need not be cleared.
- States:
  - IDLE: busy=0; ram_en=0. start=1 at an edge latches base_addr, clears rd_cnt, and moves to LOAD.
  - LOAD: ram_en=1; ram_addr = base_latched + rd_cnt, modulo 2^ADDR_W (wraps at the top of the RAM). rd_cnt increments each cycle. After the cycle with rd_cnt = DIM*DIM-1, move to DRAIN.
  - Capture pipeline: cap_vld/cap_idx are registered copies of (LOAD, rd_cnt). When cap_vld=1, buf[cap_idx] <= ram_do at the edge.
  - DRAIN: one cycle; ram_en=0. The last word is captured at the end of this cycle. Output registers load step 0 at the same edge.
  - STREAM: step counter s runs 0..2*DIM-2, one step per cycle. Outputs are registered and show step s during STREAM cycle s.
    - Lane i: if 0 <= s-i < DIM, out_data lane i = A[i][s-i] and out_lane_vld[i]=1; otherwise the lane data is 0 and its valid bit is 0.
    - out_valid=1 for all 2*DIM-1 STREAM cycles.
    - After the last step, move to IDLE and assert done=1 for exactly that one IDLE cycle.
    - Outputs return to 0 in that cycle.
  - Element mapping: buf index k = i*DIM + j holds A[i][j].
- Latency, start accepted at edge E0:
  - ram reads occupy cycles 1..DIM*DIM.
  - DRAIN is cycle DIM*DIM+1.
  - out_valid is high in cycles DIM*DIM+2 .. DIM*DIM+2*DIM.
  - done is high in cycle DIM*DIM+2*DIM+1.
  - For DIM=2: reads in cycles 1-4, stream in cycles 6-8, done in cycle 9.
- Boundary conditions:
  - start while busy=1 is ignored. base_addr changes while busy have no effect.
  - start in the done cycle (busy=0) is accepted: LOAD begins next cycle. done still pulses for its one cycle.
  - Back-to-back passes have no dead cycles beyond that.
  - Reset mid-LOAD or mid-STREAM aborts immediately; no done pulse is generated. A new start after reset performs a full pass.
  - The RAM is never written; ram_we=0 at all times, including during reset.

Test Plan:
- Operand RAM words 0..5 preset to {0,1,3,0,2,4}, DIM=2, base=1, start pulse -> ram_addr 1,2,3,4 on cycles 1-4 with ram_en=1. Stream:
  - cycle 6: lanes (1,0), vld 01.
  - cycle 7: lanes (3,0), vld 11.
  - cycle 8: lanes (0,2), vld 10.
  - done=1 in cycle 9 only.
- Same RAM, base=2 -> buffer {3,0,2,4}. Stream lanes: (3,-), then (0,2), then (-,4). Every invalid lane reads 0.
- Address wrap: base=14, RAM[14]=7, RAM[15]=8, RAM[0]=9, RAM[1]=10 -> ram_addr sequence 14,15,0,1. Stream: (7,-), (8,9), (-,10).
- start re-asserted during LOAD and STREAM -> ignored; exactly one done pulse per accepted start. start held high through the done cycle -> second pass begins the next cycle.
- rst asserted asynchronously mid-STREAM (e.g. cycle 7) -> out_valid, out_lane_vld and busy drop immediately; no done pulse. Restart with base=1 reproduces the first scenario.
- ram_we and ram_di are 0 throughout all scenarios, and ram_en is high exactly DIM*DIM cycles per pass.
